// File: rtl/tqvp_copper_pkg.sv
// Shared encodings for the raster copper: display-list opcodes, entry field
// positions, peripheral write-size codes and the sequencer state enum.
package tqvp_copper_pkg;

    localparam logic [1:0] OP_WAIT_Y = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_IRQ    = 2'b10;
    localparam logic [1:0] OP_END    = 2'b11;

    localparam logic [1:0] WR_NONE = 2'b11;
    localparam logic [1:0] WR_8    = 2'b00;
    localparam logic [1:0] WR_16   = 2'b01;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 30;
    localparam int SIZE_BIT = 22;
    localparam int ADDR_HI  = 21;
    localparam int ADDR_LO  = 16;
    localparam int DATA_HI  = 15;
    localparam int Y_HI     = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_WAIT_Y,
        ST_ISSUE,
        ST_IRQ,
        ST_HALT
    } state_t;

    function automatic logic [1:0] entry_op(input logic [31:0] entry);
        return entry[OP_HI:OP_LO];
    endfunction

endpackage

// File: rtl/tqvp_copper_list.sv
// Display-list storage: DEPTH x 32 registers, one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module tqvp_copper_list #(
    parameter int DEPTH = 16,
    parameter int PC_W  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [PC_W-1:0] waddr,
    input  logic [31:0]     wdata,
    input  logic [PC_W-1:0] raddr,
    output logic [31:0]     rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tqvp_raster_copper.sv
// Raster-synchronised copper: runs the display list once per frame and shares
// the VGA peripheral write port with the CPU (CPU always wins).
// Optional IRQ opcode support is enabled with the COPPER_IRQ_EN macro.
module tqvp_raster_copper
    import tqvp_copper_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int PC_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ctrl_en,
    input  logic            frame_start,
    input  logic [9:0]      vga_y,
    input  logic            prog_we,
    input  logic [PC_W-1:0] prog_addr,
    input  logic [31:0]     prog_data,
    input  logic [5:0]      cpu_address,
    input  logic [31:0]     cpu_data,
    input  logic [1:0]      cpu_write_n,
    output logic [5:0]      per_address,
    output logic [31:0]     per_data,
    output logic [1:0]      per_write_n,
    output logic            busy,
    output logic [PC_W-1:0] pc,
    output logic            copper_irq
);

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic [31:0]     instr;
    logic [31:0]     list_rdata;
    logic            cpu_active;
    logic            last_entry;

    tqvp_copper_list #(.DEPTH(DEPTH), .PC_W(PC_W)) u_list (
        .clk   (clk),
        .we    (prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc),
        .rdata (list_rdata)
    );

    assign cpu_active = (cpu_write_n != WR_NONE);
    assign last_entry = (pc == PC_W'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            pc    <= '0;
            instr <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (state == ST_FETCH) instr <= list_rdata;
        end
    end

    // ctrl_en beats frame_start, which beats whatever the current state wants.
    // Advancing off the last entry wraps pc to 0 and halts for the frame.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        if (!ctrl_en) begin
            state_nxt = ST_IDLE;
        end else if (frame_start) begin
            state_nxt = ST_FETCH;
            pc_nxt    = '0;
        end else begin
            case (state)
                ST_FETCH:  state_nxt = ST_DECODE;
                ST_DECODE: begin
                    case (entry_op(instr))
                        OP_WAIT_Y: state_nxt = ST_WAIT_Y;
                        OP_WRITE:  state_nxt = ST_ISSUE;
                        OP_IRQ:    state_nxt = ST_IRQ;
                        default:   state_nxt = ST_HALT;
                    endcase
                end
                ST_WAIT_Y, ST_ISSUE, ST_IRQ: begin
                    if ((state == ST_IRQ) ||
                        (state == ST_ISSUE && !cpu_active) ||
                        (state == ST_WAIT_Y && vga_y >= instr[Y_HI:0])) begin
                        pc_nxt    = pc + PC_W'(1);
                        state_nxt = last_entry ? ST_HALT : ST_FETCH;
                    end
                end
                ST_IDLE, ST_HALT: state_nxt = state;
                default:          state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        per_address = cpu_address;
        per_data    = cpu_data;
        per_write_n = cpu_write_n;
        if (!cpu_active) begin
            if (state == ST_ISSUE) begin
                per_address = instr[ADDR_HI:ADDR_LO];
                per_data    = {16'd0, instr[DATA_HI:0]};
                per_write_n = instr[SIZE_BIT] ? WR_16 : WR_8;
            end else begin
                per_write_n = WR_NONE;
            end
        end
    end

    assign busy = (state != ST_IDLE) && (state != ST_HALT);

`ifdef COPPER_IRQ_EN
    // Sticky flag; a set in the same cycle as a CPU write wins over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 copper_irq <= 1'b0;
        else if (state == ST_IRQ)   copper_irq <= 1'b1;
        else if (cpu_active)        copper_irq <= 1'b0;
    end
`else
    assign copper_irq = 1'b0;
`endif

    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[29:23];

endmodule

// File: tb/tb_tqvp_raster_copper.sv
// Directed bench for tqvp_raster_copper: hand-built display lists, cycle-exact
// checks of per_* traffic, pc/busy, arbitration, reset and the IRQ opcode.
module tb_tqvp_raster_copper;

`ifdef COPPER_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ctrl_en = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  vga_y = '0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic [5:0]  cpu_address = '0;
    logic [31:0] cpu_data = '0;
    logic [1:0]  cpu_write_n = 2'b11;
    logic [5:0]  per_address;
    logic [31:0] per_data;
    logic [1:0]  per_write_n;
    logic        busy;
    logic [3:0]  pc;
    logic        copper_irq;

    tqvp_raster_copper #(.DEPTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ctrl_en     (ctrl_en),
        .frame_start (frame_start),
        .vga_y       (vga_y),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .cpu_address (cpu_address),
        .cpu_data    (cpu_data),
        .cpu_write_n (cpu_write_n),
        .per_address (per_address),
        .per_data    (per_data),
        .per_write_n (per_write_n),
        .busy        (busy),
        .pc          (pc),
        .copper_irq  (copper_irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_wr  = 0;
    int n_cop = 0;
    int wr_sum = 0;
    logic [5:0]  s_addr;
    logic [31:0] s_data;
    logic [1:0]  s_wn;
    logic [3:0]  s_pc;
    logic        s_busy, s_irq;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Sample this cycle's outputs at the falling edge, then move to posedge+1.
    task automatic cyc();
        @(negedge clk);
        s_addr = per_address; s_data = per_data; s_wn = per_write_n;
        s_pc = pc; s_busy = busy; s_irq = copper_irq;
        if (per_write_n !== 2'b11) begin
            n_wr++;
            wr_sum += per_data;
            if (per_address == 6'h30) n_cop++;
        end
        @(posedge clk); #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic load(input int idx, input logic [31:0] d);
        prog_addr = 4'(idx); prog_data = d; prog_we = 1'b1;
        cyc();
        prog_we = 1'b0;
    endtask

    task automatic fs_pulse();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
    endtask

    task automatic load_basic();
        load(0, 32'h0000_0064);  // WAIT_Y 100
        load(1, 32'h4030_003F);  // WRITE8 0x30 <= 0x3F
        load(2, 32'hC000_0000);  // END
    endtask

    initial begin
        #12;
        check("rst_wn", per_write_n, 2'b11);
        check("rst_busy", busy, 1'b0);
        check("rst_pc", pc, 4'd0);
        check("rst_irq", copper_irq, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // CPU pass-through while idle
        cpu_address = 6'd5; cpu_data = 32'hDEAD_BEEF; cpu_write_n = 2'b10;
        cyc();
        check("cpu_pass_addr", s_addr, 6'd5);
        check("cpu_pass_data", s_data, 32'hDEAD_BEEF);
        check("cpu_pass_wn", s_wn, 2'b10);
        cpu_write_n = 2'b11;

        // Basic: WAIT_Y 100, WRITE8, END
        load_basic();
        ctrl_en = 1'b1; vga_y = 10'd0; n_wr = 0;
        fs_pulse();
        run(5);
        check("t1_nowr_early", n_wr, 0);
        check("t1_busy_wait", s_busy, 1'b1);
        check("t1_pc_wait", s_pc, 4'd0);
        vga_y = 10'd99;
        run(2);
        check("t1_nowr_99", n_wr, 0);
        vga_y = 10'd100;
        run(3);
        check("t1_decode_nowr", s_wn, 2'b11);
        cyc();
        check("t1_wn", s_wn, 2'b00);
        check("t1_addr", s_addr, 6'h30);
        check("t1_data", s_data, 32'h0000_003F);
        check("t1_pc_issue", s_pc, 4'd1);
        run(4);
        check("t1_nwr", n_wr, 1);
        check("t1_busy_halt", s_busy, 1'b0);
        check("t1_pc_halt", s_pc, 4'd2);

        // frame_start beats a satisfied WAIT_Y in the same cycle
        vga_y = 10'd0; n_wr = 0;
        fs_pulse();
        run(3);
        vga_y = 10'd100; frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        cyc();
        check("fs_wins_pc", s_pc, 4'd0);
        run(8);
        check("fs_wins_nwr", n_wr, 1);

        // CPU collides with the copper write
        vga_y = 10'd0; n_cop = 0;
        fs_pulse();
        run(3);
        vga_y = 10'd100;
        run(2);
        cpu_address = 6'h31; cpu_data = 32'h5; cpu_write_n = 2'b00;
        run(2);
        check("t2_cpu_addr", s_addr, 6'h31);
        check("t2_cpu_data", s_data, 32'h5);
        check("t2_cpu_wn", s_wn, 2'b00);
        cyc();
        check("t2_stall_addr", s_addr, 6'h31);
        cpu_write_n = 2'b11;
        cyc();
        check("t2_cop_addr", s_addr, 6'h30);
        check("t2_cop_data", s_data, 32'h3F);
        check("t2_cop_wn", s_wn, 2'b00);
        run(4);
        check("t2_ncop", n_cop, 1);
        check("t2_busy", s_busy, 1'b0);

        // WAIT_Y on a line already passed
        load(0, 32'h0000_0005);
        load(1, 32'h4052_BEEF);  // WRITE16 0x12 <= 0xBEEF
        vga_y = 10'd200; n_wr = 0;
        fs_pulse();
        run(5);
        check("t3_nowr", n_wr, 0);
        cyc();
        check("t3_wn", s_wn, 2'b01);
        check("t3_addr", s_addr, 6'h12);
        check("t3_data", s_data, 32'h0000_BEEF);
        run(3);
        check("t3_pc", s_pc, 4'd2);
        check("t3_busy", s_busy, 1'b0);

        // Full list, no END: 16 writes then wrap to pc 0 and halt
        for (int i = 0; i < 16; i++)
            load(i, 32'h4040_0000 | (32'(i) << 16) | (32'h1000 + 32'(i)));
        for (int f = 0; f < 2; f++) begin
            n_wr = 0; wr_sum = 0;
            fs_pulse();
            run(51);
            check("t4_nwr", n_wr, 16);
            check("t4_sum", wr_sum, 65656);
            check("t4_pc", s_pc, 4'd0);
            check("t4_busy", s_busy, 1'b0);
        end

        // ctrl_en dropped while waiting
        load_basic();
        vga_y = 10'd0; n_wr = 0;
        fs_pulse();
        run(3);
        ctrl_en = 1'b0;
        cyc();
        vga_y = 10'd100;
        run(6);
        check("t5_nwr", n_wr, 0);
        check("t5_busy", s_busy, 1'b0);
        ctrl_en = 1'b1;
        run(2);
        check("t5_nwr_idle", n_wr, 0);

        // Reset in the middle of ISSUE
        fs_pulse();
        run(5);
        check("t5_issue_wn", per_write_n, 2'b00);
        rst_n = 1'b0;
        #1;
        check("t5_rst_wn", per_write_n, 2'b11);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_pc", pc, 4'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        n_cop = 0;
        fs_pulse();
        run(10);
        check("t5_list_kept", n_cop, 1);

        // IRQ opcode
        load(0, 32'h8000_0000);
        load(1, 32'hC000_0000);
        fs_pulse();
        run(3);
        check("t6_irq_pre", s_irq, 1'b0);
        cyc();
        check("t6_irq_set", s_irq, IRQ_EN);
        run(3);
        check("t6_irq_hold", s_irq, IRQ_EN);
        check("t6_pc", s_pc, 4'd1);
        check("t6_busy", s_busy, 1'b0);
        cpu_address = 6'h0; cpu_data = '0; cpu_write_n = 2'b00;
        cyc();
        check("t6_irq_clr_cyc", s_irq, IRQ_EN);
        cpu_write_n = 2'b11;
        cyc();
        check("t6_irq_clr", s_irq, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
